// File: rtl/pll_seq_pkg.sv
// ============================================================================
// Module   : pll_seq_pkg
// Brief    : Shared types and widths for the PLL lock sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_seq_pkg;

    localparam int SEL_W   = 6;
    localparam int LOSS_W  = 8;
    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        WAIT   = 3'd1,
        STABLE = 3'd2,
        RUN    = 3'd3,
        RECONF = 3'd4,
        FAIL   = 3'd5
    } pll_state_e;

    // States in which the PLL must be held in reset.
    function automatic logic state_holds_pll(input pll_state_e s);
        return (s == HOLD) || (s == RECONF) || (s == FAIL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for a single asynchronous level, resets to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
// ============================================================================
// Module   : pll_lock_sequencer
// Brief    : Reset/lock sequencer and runtime reconfiguration for one rPLL.
//            Define PLL_SEQ_LOSS_CNT_EN to build the loss-of-lock counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int               RST_CYCLES   = 16,
    parameter int               LOCK_TIMEOUT = 65535,
    parameter int               LOCK_STABLE  = 1024,
    parameter int               MAX_RETRY    = 3,
    parameter int               CNT_W        = 16,
    parameter logic [SEL_W-1:0] INIT_FBDSEL  = 6'd0,
    parameter logic [SEL_W-1:0] INIT_IDSEL   = 6'd0,
    parameter logic [SEL_W-1:0] INIT_ODSEL   = 6'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock_i,
    output logic              pll_reset_o,
    output logic [SEL_W-1:0]  pll_fbdsel_o,
    output logic [SEL_W-1:0]  pll_idsel_o,
    output logic [SEL_W-1:0]  pll_odsel_o,
    input  logic              cfg_req_i,
    input  logic [SEL_W-1:0]  cfg_fbdsel_i,
    input  logic [SEL_W-1:0]  cfg_idsel_i,
    input  logic [SEL_W-1:0]  cfg_odsel_i,
    output logic              cfg_ack_o,
    output logic              sys_rst_n_o,
    output logic              locked_o,
    output logic              fail_o,
    output logic [LOSS_W-1:0] loss_cnt_o
);

    localparam logic [CNT_W-1:0]   c_rst_load     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_timeout_load = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT cycle that first sees lock already counts toward stability.
    localparam logic [CNT_W-1:0]   c_stable_load  = CNT_W'(LOCK_STABLE - 2);
    localparam logic [RETRY_W-1:0] c_last_retry   = RETRY_W'(MAX_RETRY - 1);

    logic lock_s;

    pll_state_e         state_q,       state_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [RETRY_W-1:0] retry_q,       retry_d;
    logic [SEL_W-1:0]   fbdsel_q,      fbdsel_d;
    logic [SEL_W-1:0]   idsel_q,       idsel_d;
    logic [SEL_W-1:0]   odsel_q,       odsel_d;
    logic               reconf_pend_q, reconf_pend_d;
    logic               pll_reset_q,   pll_reset_d;
    logic               sys_rst_n_q,   sys_rst_n_d;
    logic               locked_q,      locked_d;
    logic               cfg_ack_q,     cfg_ack_d;
    logic               fail_q,        fail_d;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        retry_d       = retry_q;
        fbdsel_d      = fbdsel_q;
        idsel_d       = idsel_q;
        odsel_d       = odsel_q;
        reconf_pend_d = reconf_pend_q;

        case (state_q)
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = WAIT;
                    cnt_d   = c_timeout_load;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = c_stable_load;
                end else if (cnt_q == '0) begin
                    retry_d = retry_q + 1'b1;
                    if (retry_q == c_last_retry) begin
                        state_d = FAIL;
                        cnt_d   = '0;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = c_rst_load;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT;
                    cnt_d   = c_timeout_load;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                retry_d = '0;
                // The ack cycle still sees the request that is being acknowledged.
                if (!lock_s) begin
                    state_d = HOLD;
                    cnt_d   = c_rst_load;
                end else if (cfg_req_i && !cfg_ack_q) begin
                    state_d  = RECONF;
                    cnt_d    = '0;
                    fbdsel_d = cfg_fbdsel_i;
                    idsel_d  = cfg_idsel_i;
                    odsel_d  = cfg_odsel_i;
                end
            end
            RECONF: begin
                state_d       = HOLD;
                cnt_d         = c_rst_load;
                reconf_pend_d = 1'b1;
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = FAIL;
                cnt_d   = '0;
            end
        endcase

        cfg_ack_d = (state_d == RUN) && (state_q != RUN) && reconf_pend_q;
        if (cfg_ack_d) begin
            reconf_pend_d = 1'b0;
        end

        pll_reset_d = state_holds_pll(state_d);
        sys_rst_n_d = (state_d == RUN);
        locked_d    = (state_d == RUN);
        fail_d      = fail_q || (state_d == FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HOLD;
            cnt_q         <= c_rst_load;
            retry_q       <= '0;
            fbdsel_q      <= INIT_FBDSEL;
            idsel_q       <= INIT_IDSEL;
            odsel_q       <= INIT_ODSEL;
            reconf_pend_q <= 1'b0;
            pll_reset_q   <= 1'b1;
            sys_rst_n_q   <= 1'b0;
            locked_q      <= 1'b0;
            cfg_ack_q     <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            fbdsel_q      <= fbdsel_d;
            idsel_q       <= idsel_d;
            odsel_q       <= odsel_d;
            reconf_pend_q <= reconf_pend_d;
            pll_reset_q   <= pll_reset_d;
            sys_rst_n_q   <= sys_rst_n_d;
            locked_q      <= locked_d;
            cfg_ack_q     <= cfg_ack_d;
            fail_q        <= fail_d;
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic              loss_evt;
    logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;

    assign loss_evt = (state_q == RUN) && !lock_s;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_evt && (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt_o = loss_cnt_q;
`else
    assign loss_cnt_o = '0;
`endif

    assign pll_reset_o  = pll_reset_q;
    assign pll_fbdsel_o = fbdsel_q;
    assign pll_idsel_o  = idsel_q;
    assign pll_odsel_o  = odsel_q;
    assign cfg_ack_o    = cfg_ack_q;
    assign sys_rst_n_o  = sys_rst_n_q;
    assign locked_o     = locked_q;
    assign fail_o       = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
// ============================================================================
// Module   : tb_pll_lock_sequencer
// Brief    : Directed self-checking bench for pll_lock_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_sequencer;

    localparam logic [5:0] C_INIT_FB = 6'h10;
    localparam logic [5:0] C_INIT_ID = 6'h01;
    localparam logic [5:0] C_INIT_OD = 6'h02;

`ifdef PLL_SEQ_LOSS_CNT_EN
    localparam logic [7:0] C_LOSS_AFTER_DROP = 8'd1;
`else
    localparam logic [7:0] C_LOSS_AFTER_DROP = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock_i = 1'b0;
    logic       cfg_req_i = 1'b0;
    logic [5:0] cfg_fbdsel_i = '0;
    logic [5:0] cfg_idsel_i = '0;
    logic [5:0] cfg_odsel_i = '0;
    logic       pll_reset_o;
    logic [5:0] pll_fbdsel_o, pll_idsel_o, pll_odsel_o;
    logic       cfg_ack_o, sys_rst_n_o, locked_o, fail_o;
    logic [7:0] loss_cnt_o;

    int tests = 0;
    int fails = 0;
    logic ack_seen;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .LOCK_STABLE  (8),
        .MAX_RETRY    (3),
        .CNT_W        (16),
        .INIT_FBDSEL  (C_INIT_FB),
        .INIT_IDSEL   (C_INIT_ID),
        .INIT_ODSEL   (C_INIT_OD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock_i   (pll_lock_i),
        .pll_reset_o  (pll_reset_o),
        .pll_fbdsel_o (pll_fbdsel_o),
        .pll_idsel_o  (pll_idsel_o),
        .pll_odsel_o  (pll_odsel_o),
        .cfg_req_i    (cfg_req_i),
        .cfg_fbdsel_i (cfg_fbdsel_i),
        .cfg_idsel_i  (cfg_idsel_i),
        .cfg_odsel_i  (cfg_odsel_i),
        .cfg_ack_o    (cfg_ack_o),
        .sys_rst_n_o  (sys_rst_n_o),
        .locked_o     (locked_o),
        .fail_o       (fail_o),
        .loss_cnt_o   (loss_cnt_o)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick(3);
        check("rst_pll_reset", 32'(pll_reset_o), 32'd1);
        check("rst_sys_rst_n", 32'(sys_rst_n_o), 32'd0);
        check("rst_locked",    32'(locked_o),    32'd0);
        check("rst_ack",       32'(cfg_ack_o),   32'd0);
        check("rst_fail",      32'(fail_o),      32'd0);
        check("rst_fbdsel",    32'(pll_fbdsel_o), 32'(C_INIT_FB));
        check("rst_loss",      32'(loss_cnt_o),  32'd0);

        // 1: lock 10 cycles after pll_reset falls, release 2+8 cycles later
        rst_n = 1'b1;
        tick(3);
        check("t1_hold_3", 32'(pll_reset_o), 32'd1);
        tick(1);
        check("t1_hold_end", 32'(pll_reset_o), 32'd0);
        tick(10);
        pll_lock_i = 1'b1;
        tick(9);
        check("t1_pre_release", 32'(sys_rst_n_o), 32'd0);
        tick(1);
        check("t1_release", 32'(sys_rst_n_o), 32'd1);
        check("t1_locked",  32'(locked_o),    32'd1);

        // 4: loss of lock in RUN
        pll_lock_i = 1'b0;
        tick(2);
        check("t4_still_run", 32'(sys_rst_n_o), 32'd1);
        tick(1);
        check("t4_sys_rst_low", 32'(sys_rst_n_o), 32'd0);
        check("t4_pll_reset",   32'(pll_reset_o), 32'd1);
        check("t4_loss_cnt",    32'(loss_cnt_o),  32'(C_LOSS_AFTER_DROP));
        tick(3);
        check("t4_hold_4th", 32'(pll_reset_o), 32'd1);
        tick(1);
        check("t4_hold_end", 32'(pll_reset_o), 32'd0);

        // 3: single-cycle glitch during STABLE
        pll_lock_i = 1'b1;
        tick(5);
        pll_lock_i = 1'b0;
        tick(1);
        pll_lock_i = 1'b1;
        tick(4);
        check("t3_no_early_release", 32'(sys_rst_n_o), 32'd0);
        tick(5);
        check("t3_pre_release", 32'(sys_rst_n_o), 32'd0);
        tick(1);
        check("t3_release", 32'(sys_rst_n_o), 32'd1);

        // 5: reconfiguration handshake
        cfg_req_i    = 1'b1;
        cfg_fbdsel_i = 6'h34;
        cfg_idsel_i  = 6'h05;
        cfg_odsel_i  = 6'h07;
        tick(1);
        check("t5_fbdsel_new",  32'(pll_fbdsel_o), 32'h34);
        check("t5_pll_reset",   32'(pll_reset_o),  32'd1);
        check("t5_sys_rst_low", 32'(sys_rst_n_o),  32'd0);
        check("t5_unlocked",    32'(locked_o),     32'd0);
        pll_lock_i = 1'b0;
        tick(5);
        check("t5_hold_end", 32'(pll_reset_o), 32'd0);
        pll_lock_i = 1'b1;
        tick(9);
        check("t5_no_early_ack", 32'(cfg_ack_o), 32'd0);
        tick(1);
        check("t5_ack",     32'(cfg_ack_o),    32'd1);
        check("t5_run",     32'(sys_rst_n_o),  32'd1);
        check("t5_idsel",   32'(pll_idsel_o),  32'h05);
        check("t5_odsel",   32'(pll_odsel_o),  32'h07);
        cfg_req_i = 1'b0;
        tick(1);
        check("t5_ack_one_cycle", 32'(cfg_ack_o), 32'd0);
        check("t5_stays_locked",  32'(locked_o),  32'd1);
        tick(5);
        check("t5_fbdsel_kept", 32'(pll_fbdsel_o), 32'h34);
        check("t5_no_reack",    32'(cfg_ack_o),    32'd0);

        // 6: rst_n during reconfiguration
        cfg_req_i    = 1'b1;
        cfg_fbdsel_i = 6'h2A;
        tick(1);
        check("t6_in_reconf", 32'(pll_fbdsel_o), 32'h2A);
        rst_n      = 1'b0;
        cfg_req_i  = 1'b0;
        pll_lock_i = 1'b0;
        #1;
        check("t6_fbdsel_init", 32'(pll_fbdsel_o), 32'(C_INIT_FB));
        check("t6_odsel_init",  32'(pll_odsel_o),  32'(C_INIT_OD));
        check("t6_pll_reset",   32'(pll_reset_o),  32'd1);
        check("t6_loss_clr",    32'(loss_cnt_o),   32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("t6_hold_3", 32'(pll_reset_o), 32'd1);
        tick(1);
        check("t6_hold_end", 32'(pll_reset_o), 32'd0);
        pll_lock_i = 1'b1;
        ack_seen   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            ack_seen = ack_seen | cfg_ack_o;
        end
        check("t6_relocked", 32'(sys_rst_n_o), 32'd1);
        check("t6_no_ack",   32'(ack_seen),    32'd0);

        // 2: lock never arrives -> three attempts then sticky fail
        rst_n      = 1'b0;
        pll_lock_i = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(24);
        check("t2_retry1_hold", 32'(pll_reset_o), 32'd1);
        check("t2_retry1_nofail", 32'(fail_o), 32'd0);
        tick(47);
        check("t2_last_wait_pll",  32'(pll_reset_o), 32'd0);
        check("t2_last_wait_fail", 32'(fail_o),      32'd0);
        tick(1);
        check("t2_fail",      32'(fail_o),      32'd1);
        check("t2_fail_pll",  32'(pll_reset_o), 32'd1);
        pll_lock_i = 1'b1;
        tick(15);
        check("t2_fail_sticky", 32'(fail_o),      32'd1);
        check("t2_fail_hold",   32'(pll_reset_o), 32'd1);
        check("t2_fail_sysrst", 32'(sys_rst_n_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t2_fail_cleared", 32'(fail_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
